// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding, pattern width and reset pattern
package seq_pkg;

    localparam int PAT_W = 4;
    localparam logic [PAT_W-1:0] RESET_PATTERN = 4'b1010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_match4.sv
// rtl/seq_match4.sv - overlapping 4-bit serial pattern detector, registered match
module seq_match4
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic [PAT_W-1:0] pattern,
    input  logic             clr,
    output logic             match
);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [2:0]       seen_q, seen_d;
    logic             match_q, match_d;
    logic [PAT_W-1:0] window;

    assign window = {hist_q, bit_in};

    // seen_q saturates at 4 so a match needs a full window since the last clear
    always_comb begin
        hist_d  = hist_q;
        seen_d  = seen_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            seen_d = '0;
        end else if (bit_en) begin
            hist_d  = window[PAT_W-2:0];
            match_d = (window == pattern) && (seen_q >= 3'd3);
            if (seen_q != 3'd4) begin
                seen_d = seen_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-bit scanner with pattern match counter and irq
module pattern_scan_ctrl
    import seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              irq_clr,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_q, irq_d;

    logic              shifting;
    logic              accept;
    logic              cfg_ok;
    logic [CNT_W-1:0]  count_base;
    logic              count_inc;

    assign shifting = (state_q == ST_SHIFT);
    assign in_ready = (state_q == ST_IDLE) || (bit_cnt_q == '0);
    assign accept   = in_valid && in_ready;
    assign cfg_ok   = cfg_we && (state_q == ST_IDLE) && !accept;

    // Accept on the last scan cycle reloads so words stream with no bubble
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            state_d   = ST_SHIFT;
            sr_d      = in_data;
            bit_cnt_d = LAST_BIT;
        end else if (shifting) begin
            sr_d = {sr_q[DATA_W-2:0], 1'b0};
            if (bit_cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        pattern_d = cfg_ok ? cfg_pattern : pattern_q;
        thresh_d  = cfg_ok ? cfg_thresh  : thresh_q;
    end

    // Clear takes effect before a coincident match is counted
    always_comb begin
        count_base = irq_clr ? '0 : count_q;
        count_inc  = match_pulse && (count_base != CNT_MAX);
        count_d    = count_base + CNT_W'(count_inc);
        irq_d      = irq_clr ? 1'b0 : irq_q;
        if (count_inc && (thresh_q != '0) && (count_d == thresh_q)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            pattern_q <= RESET_PATTERN;
            thresh_q  <= '0;
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            pattern_q <= pattern_d;
            thresh_q  <= thresh_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
        end
    end

    seq_match4 u_match (
        .clk     (clk),
        .rst     (rst),
        .bit_in  (sr_q[DATA_W-1]),
        .bit_en  (shifting),
        .pattern (pattern_q),
        .clr     (cfg_ok),
        .match   (match_pulse)
    );

    assign busy        = shifting;
    assign match_count = count_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b1010;
    logic [7:0] cfg_thresh = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       irq_clr = 1'b0;
    logic       in_ready, busy, match_pulse, irq;
    logic [7:0] match_count;
    logic       in_ready2, busy2, match_pulse2, irq2;
    logic [1:0] match_count2;

    int total = 0;
    int bad = 0;

    logic [31:0] pulse_m, pulse2_m, irq_m, ready_m, busy_m;
    logic [7:0]  cnt_a [0:31];

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .irq_clr(irq_clr), .busy(busy),
        .match_pulse(match_pulse), .match_count(match_count), .irq(irq)
    );

    pattern_scan_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_thresh(cfg_thresh[1:0]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .irq_clr(irq_clr), .busy(busy2),
        .match_pulse(match_pulse2), .match_count(match_count2), .irq(irq2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        irq_clr = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] p, input logic [7:0] t);
        cfg_pattern = p;
        cfg_thresh = t;
        cfg_we = 1'b1;
        step;
        cfg_we = 1'b0;
    endtask

    // Observation i is taken just after the i-th edge following the accepting edge
    task automatic run_word(input logic [7:0] d0, input logic [7:0] d1, input bit two,
                            input int n, input int cfg_at, input int clr_at);
        pulse_m = '0; pulse2_m = '0; irq_m = '0; ready_m = '0; busy_m = '0;
        in_valid = 1'b1;
        in_data = d0;
        step;
        if (two) in_data = d1;
        else in_valid = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (i == cfg_at) cfg_we = 1'b1;
            if (i == clr_at) irq_clr = 1'b1;
            step;
            cfg_we = 1'b0;
            irq_clr = 1'b0;
            pulse_m[i] = match_pulse;
            pulse2_m[i] = match_pulse2;
            irq_m[i] = irq;
            ready_m[i] = in_ready;
            busy_m[i] = busy;
            cnt_a[i] = match_count;
            if (two && i == 8) in_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (match_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", match_pulse); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", match_count); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_basic_scan;
        do_reset;
        run_word(8'hAA, 8'h00, 1'b0, 10, 0, 0);
        total++; if (pulse_m !== 32'h150) begin bad++; $display("FAIL scan_pulses got=%h exp=%h", pulse_m, 32'h150); end
        total++; if (cnt_a[10] !== 8'd3) begin bad++; $display("FAIL scan_count got=%0d exp=3", cnt_a[10]); end
        total++; if (busy_m[7] !== 1'b1) begin bad++; $display("FAIL scan_busy7 got=%b exp=1", busy_m[7]); end
        total++; if (busy_m[8] !== 1'b0) begin bad++; $display("FAIL scan_busy8 got=%b exp=0", busy_m[8]); end
        total++; if (ready_m[3] !== 1'b0) begin bad++; $display("FAIL scan_ready3 got=%b exp=0", ready_m[3]); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        run_word(8'h05, 8'h00, 1'b1, 17, 0, 0);
        total++; if (pulse_m !== 32'h200) begin bad++; $display("FAIL b2b_pulses got=%h exp=%h", pulse_m, 32'h200); end
        total++; if (ready_m[7] !== 1'b1) begin bad++; $display("FAIL b2b_ready7 got=%b exp=1", ready_m[7]); end
        total++; if (busy_m[8] !== 1'b1) begin bad++; $display("FAIL b2b_busy8 got=%b exp=1", busy_m[8]); end
        total++; if (busy_m[16] !== 1'b0) begin bad++; $display("FAIL b2b_busy16 got=%b exp=0", busy_m[16]); end
        total++; if (cnt_a[17] !== 8'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", cnt_a[17]); end
    endtask

    task automatic test_irq;
        do_reset;
        cfg_write(4'b1010, 8'd3);
        run_word(8'hAA, 8'h00, 1'b0, 10, 0, 0);
        total++; if (irq_m[8] !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq_m[8]); end
        total++; if (irq_m[9] !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq_m[9]); end
        total++; if (cnt_a[9] !== 8'd3) begin bad++; $display("FAIL irq_count got=%0d exp=3", cnt_a[9]); end
        irq_clr = 1'b1;
        step;
        irq_clr = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr_irq got=%b exp=0", irq); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL irq_clr_count got=%0d exp=0", match_count); end
    endtask

    task automatic test_clr_with_match;
        do_reset;
        cfg_write(4'b1010, 8'd2);
        run_word(8'hAA, 8'h00, 1'b0, 10, 0, 7);
        total++; if (cnt_a[5] !== 8'd1) begin bad++; $display("FAIL cwm_count5 got=%0d exp=1", cnt_a[5]); end
        total++; if (cnt_a[7] !== 8'd1) begin bad++; $display("FAIL cwm_count7 got=%0d exp=1", cnt_a[7]); end
        total++; if (irq_m[7] !== 1'b0) begin bad++; $display("FAIL cwm_irq7 got=%b exp=0", irq_m[7]); end
        total++; if (cnt_a[9] !== 8'd2) begin bad++; $display("FAIL cwm_count9 got=%0d exp=2", cnt_a[9]); end
        total++; if (irq_m[9] !== 1'b1) begin bad++; $display("FAIL cwm_irq9 got=%b exp=1", irq_m[9]); end
    endtask

    task automatic test_saturate;
        int n2;
        do_reset;
        run_word(8'hAA, 8'h00, 1'b0, 10, 0, 0);
        n2 = $countones(pulse2_m);
        cfg_write(4'b1010, 8'd0);
        run_word(8'hAA, 8'h00, 1'b0, 10, 0, 0);
        n2 += $countones(pulse2_m);
        total++; if (n2 != 6) begin bad++; $display("FAIL sat_pulses got=%0d exp=6", n2); end
        total++; if (match_count2 !== 2'd3) begin bad++; $display("FAIL sat_count2 got=%0d exp=3", match_count2); end
        total++; if (match_count !== 8'd6) begin bad++; $display("FAIL sat_count8 got=%0d exp=6", match_count); end
    endtask

    task automatic test_cfg;
        do_reset;
        cfg_pattern = 4'b0110;
        cfg_thresh = 8'd0;
        run_word(8'h66, 8'h00, 1'b0, 10, 3, 0);
        total++; if (pulse_m !== 32'h0) begin bad++; $display("FAIL cfg_ignored got=%h exp=0", pulse_m); end
        cfg_write(4'b0110, 8'd0);
        run_word(8'h66, 8'h00, 1'b0, 10, 0, 0);
        total++; if (pulse_m !== 32'h110) begin bad++; $display("FAIL cfg_pulses got=%h exp=%h", pulse_m, 32'h110); end
        total++; if (match_count !== 8'd2) begin bad++; $display("FAIL cfg_count got=%0d exp=2", match_count); end
    endtask

    task automatic test_reset_mid_shift;
        int npulse;
        logic bad_state;
        do_reset;
        in_valid = 1'b1;
        in_data = 8'hAA;
        step;
        in_valid = 1'b0;
        step;
        step;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        #2;
        rst = 1'b1;
        npulse = 0;
        bad_state = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (match_pulse) npulse++;
            if (busy !== 1'b0 || in_ready !== 1'b1) bad_state = 1'b1;
        end
        total++; if (npulse != 0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=0", npulse); end
        total++; if (bad_state !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b exp=0", bad_state); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", match_count); end
    endtask

    initial begin
        test_reset;
        test_basic_scan;
        test_back_to_back;
        test_irq;
        test_clr_with_match;
        test_saturate;
        test_cfg;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input word width (≥2).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_pattern  input  4  pattern to detect, first bit = bit 3.
REQ-007 SHALL have port cfg_thresh  input  CNT_W  irq threshold; 0 = irq disabled.
REQ-008 SHALL have port in_valid  input  1  word valid.
REQ-009 SHALL have port in_data  input  DATA_W  word, scanned MSB first.
REQ-010 SHALL have port in_ready  output  1  word accepted when in_valid & in_ready.
REQ-011 SHALL have port irq_clr  input  1  clears irq and match_count.
REQ-012 SHALL have port busy  output  1  high while in SHIFT.
REQ-013 SHALL have port match_pulse  output  1  one-cycle pulse per detected match.
REQ-014 SHALL have port match_count  output  CNT_W  saturating match count.
REQ-015 SHALL have port irq  output  1  sticky threshold interrupt.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT.
REQ-017 IDLE: in_ready=1; on accept, load in_data into shift register, bit_cnt=DATA_W-1, go SHIFT.
REQ-018 SHIFT: each cycle present shift-register MSB to detector, shift left, decrement bit_cnt.
REQ-019 SHIFT with bit_cnt==0: in_ready=1; accept reloads and stays in SHIFT (one word per DATA_W cycles back-to-back), else go IDLE.
REQ-020 Detection SHALL be overlapping; detector history SHALL persist across word boundaries and idle gaps.
REQ-021 Match SHALL occur when the last 4 presented bits equal cfg pattern and ≥4 bits presented since history clear.
REQ-022 match_pulse SHALL assert the cycle after the completing bit is presented (latency 1).
REQ-023 match_count SHALL increment on each match_pulse, saturating at 2^CNT_W-1.
REQ-024 irq SHALL set the cycle match_count becomes equal to nonzero threshold; held until irq_clr.
REQ-025 irq_clr with simultaneous match: clear applies first, count becomes 1, irq set only if thresh==1.
REQ-026 cfg_we SHALL be accepted only in IDLE without simultaneous accept; ignored otherwise.
REQ-027 Accepted cfg_we SHALL load pattern and threshold and clear detector history; count/irq unchanged.

Reset
REQ-028 rst low SHALL force IDLE, pattern=4'b1010, thresh=0, history cleared, shift register 0, bit_cnt 0.
REQ-029 Reset outputs: in_ready=1 after release, busy=0, match_pulse=0, match_count=0, irq=0.
REQ-030 Reset mid-SHIFT SHALL discard the partially scanned word without a match_pulse.

Structure
REQ-031 State encoding, pattern width (4) and reset pattern SHALL live in shared package seq_pkg.
REQ-032 Detector SHALL be sub-module seq_match4 (bit_in, bit_en, pattern, clr -> match), instanced once.

Verification
REQ-033 Reset, pattern 1010, word 0xAA -> 3 match_pulses on scan cycles 4, 6, 8 (+1 latency), count=3.
REQ-034 Word 0x05 then 0x00 back-to-back -> one match spanning boundary, in_ready never low between words.
REQ-035 Threshold 3, word 0xAA -> irq rises with count 3; irq_clr with no match -> irq=0, count=0.
REQ-036 CNT_W=2, feed 0xAA twice -> count saturates at 3, match_pulse still fires 6 times.
REQ-037 cfg_we during SHIFT -> ignored; cfg_we pattern 0110 in IDLE, word 0x66 -> 2 matches.
REQ-038 rst low at scan cycle 3 of 0xAA -> no match_pulse, busy=0, in_ready=1 after release.
